// File: rtl/branch_resolve_unit.sv
// Branch resolution for the execute stage, plus the small generic FIFO used for its BTB training queue.

// Generic single-clock FIFO; DEPTH must be a power of two.
// Latency: a write is visible at the read side on the cycle after the push.
// Backpressure: wr_rdy drops only when full and no pop happens in the same cycle.
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    output logic         wr_rdy,
    output logic         rd_vld,
    output logic [W-1:0] rd_dat,
    input  logic         rd_rdy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign rd_vld  = (cnt != '0);
    assign do_pop  = rd_vld && rd_rdy;
    // A full queue still takes a write when the head leaves in the same cycle.
    assign wr_rdy  = (cnt != FULL_CNT) || do_pop;
    assign do_push = wr_vld && wr_rdy;
    assign rd_dat  = rd_vld ? mem[rp] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wp] <= wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) begin
                wp <= wp + AW'(1);
            end
            if (do_pop) begin
                rp <= rp + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// Resolves fetch-time BTB predictions in EX; redirects and flushes on a mispredict, queues BTB training.
// Latency: resolve in cycle N; redirect, flush and queue write appear in N+1.
// Backpressure: training requests wait on upd_ready; a push into a full, non-popping queue is dropped and counted.
module branch_resolve_unit #(
    parameter int PC_W         = 16,
    parameter int FLUSH_CYCLES = 2,
    parameter int UQ_DEPTH     = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             f_valid,
    input  logic [PC_W-1:0]  f_pc,
    input  logic             f_pred_taken,
    input  logic [PC_W-1:0]  f_pred_tgt,
    input  logic             ex_valid,
    input  logic [PC_W-1:0]  ex_pc,
    input  logic [3:0]       ex_opcode,
    input  logic [PC_W-1:0]  ex_target,
    input  logic             lflag,
    input  logic             gflag,
    input  logic             zflag,
    output logic             flush,
    output logic             redirect_vld,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             upd_valid,
    input  logic             upd_ready,
    output logic [PC_W-1:0]  upd_pc,
    output logic [PC_W-1:0]  upd_target,
    output logic             upd_taken,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt,
    output logic [CNT_W-1:0] drop_cnt
);
    localparam logic [3:0] OP_JUMP   = 4'b0110;
    localparam logic [3:0] OP_JUMPL  = 4'b0111;
    localparam logic [3:0] OP_JUMPG  = 4'b1000;
    localparam logic [3:0] OP_JUMPE  = 4'b1001;
    localparam logic [3:0] OP_JUMPNE = 4'b1010;
    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef struct packed {
        logic            valid;
        logic            taken;
        logic [PC_W-1:0] tgt;
        logic [PC_W-1:0] pc;
    } pred_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] tgt;
        logic            taken;
    } upd_t;

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [FC_W-1:0] fcnt;
    logic [FC_W-1:0] fcnt_nxt;
    pred_t           d_q;
    pred_t           ex_q;
    logic            is_jump;
    logic            cond;
    logic            pred_taken;
    logic            mispredict;
    logic            push;
    logic            push_rdy;
    upd_t            push_dat;
    upd_t            head;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] actual_next;

    // Flush wins over stall so killed slots never resolve later.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q  <= '0;
            ex_q <= '0;
        end else begin
            if (!stall) begin
                d_q  <= '{valid: f_valid, taken: f_pred_taken, tgt: f_pred_tgt, pc: f_pc};
                ex_q <= d_q;
            end
            if (flush) begin
                d_q.valid  <= 1'b0;
                ex_q.valid <= 1'b0;
            end
        end
    end

    always_comb begin
        is_jump = 1'b0;
        cond    = 1'b0;
        case (ex_opcode)
            OP_JUMP:   begin is_jump = 1'b1; cond = 1'b1;   end
            OP_JUMPL:  begin is_jump = 1'b1; cond = lflag;  end
            OP_JUMPG:  begin is_jump = 1'b1; cond = gflag;  end
            OP_JUMPE:  begin is_jump = 1'b1; cond = zflag;  end
            OP_JUMPNE: begin is_jump = 1'b1; cond = ~zflag; end
            default:   begin is_jump = 1'b0; cond = 1'b0;   end
        endcase
    end

    // A prediction whose PC no longer matches EX is stale and counts as not-taken.
    assign pred_taken  = ex_q.valid && (ex_q.pc == ex_pc) && ex_q.taken;
    assign pc_inc      = ex_pc + PC_W'(1);
    assign actual_next = (is_jump && cond) ? ex_target : pc_inc;

    always_comb begin
        mispredict = 1'b0;
        push       = 1'b0;
        push_dat   = '0;
        if ((state == IDLE) && ex_valid) begin
            if (is_jump) begin
                push           = 1'b1;
                push_dat.pc    = ex_pc;
                push_dat.tgt   = ex_target;
                push_dat.taken = cond;
                mispredict     = (pred_taken != cond) ||
                                 (cond && pred_taken && (ex_q.tgt != ex_target));
            end else if (pred_taken) begin
                push           = 1'b1;
                push_dat.pc    = ex_pc;
                push_dat.tgt   = pc_inc;
                push_dat.taken = 1'b0;
                mispredict     = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        fcnt_nxt  = fcnt;
        flush     = 1'b0;
        case (state)
            IDLE: begin
                if (mispredict) begin
                    state_nxt = FLUSH;
                    fcnt_nxt  = FC_W'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                flush = 1'b1;
                if (fcnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    fcnt_nxt = fcnt - FC_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            fcnt         <= '0;
            redirect_vld <= 1'b0;
            redirect_pc  <= '0;
        end else begin
            state        <= state_nxt;
            fcnt         <= fcnt_nxt;
            redirect_vld <= mispredict;
            if (mispredict) begin
                redirect_pc <= actual_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
            drop_cnt    <= '0;
        end else begin
            if (push && is_jump && (branch_cnt != '1)) begin
                branch_cnt <= branch_cnt + CNT_W'(1);
            end
            if (mispredict && (mispred_cnt != '1)) begin
                mispred_cnt <= mispred_cnt + CNT_W'(1);
            end
            if (push && !push_rdy && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end

    fifo #(
        .W     ($bits(upd_t)),
        .DEPTH (UQ_DEPTH)
    ) u_upd_q (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (push),
        .wr_dat (push_dat),
        .wr_rdy (push_rdy),
        .rd_vld (upd_valid),
        .rd_dat (head),
        .rd_rdy (upd_ready)
    );

    assign upd_pc     = head.pc;
    assign upd_target = head.tgt;
    assign upd_taken  = head.taken;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: one task per scenario, hand-computed expectations.
module tb_branch_resolve_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        f_valid;
    logic [15:0] f_pc;
    logic        f_pred_taken;
    logic [15:0] f_pred_tgt;
    logic        ex_valid;
    logic [15:0] ex_pc;
    logic [3:0]  ex_opcode;
    logic [15:0] ex_target;
    logic        lflag, gflag, zflag;
    logic        flush;
    logic        redirect_vld;
    logic [15:0] redirect_pc;
    logic        upd_valid;
    logic        upd_ready;
    logic [15:0] upd_pc;
    logic [15:0] upd_target;
    logic        upd_taken;
    logic [15:0] branch_cnt, mispred_cnt, drop_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .f_valid      (f_valid),
        .f_pc         (f_pc),
        .f_pred_taken (f_pred_taken),
        .f_pred_tgt   (f_pred_tgt),
        .ex_valid     (ex_valid),
        .ex_pc        (ex_pc),
        .ex_opcode    (ex_opcode),
        .ex_target    (ex_target),
        .lflag        (lflag),
        .gflag        (gflag),
        .zflag        (zflag),
        .flush        (flush),
        .redirect_vld (redirect_vld),
        .redirect_pc  (redirect_pc),
        .upd_valid    (upd_valid),
        .upd_ready    (upd_ready),
        .upd_pc       (upd_pc),
        .upd_target   (upd_target),
        .upd_taken    (upd_taken),
        .branch_cnt   (branch_cnt),
        .mispred_cnt  (mispred_cnt),
        .drop_cnt     (drop_cnt)
    );

    // Fetch a prediction, let it ride to EX, then present the real instruction there.
    // Returns at the negedge after the resolving posedge, when N+1 outputs are visible.
    task automatic issue(input logic [15:0] fpc, input logic ptk, input logic [15:0] ptgt,
                         input logic [15:0] epc, input logic [3:0] op, input logic [15:0] tgt,
                         input logic l, input logic g, input logic z, input logic rdy);
        f_valid = 1'b1; f_pc = fpc; f_pred_taken = ptk; f_pred_tgt = ptgt;
        @(negedge clk);
        f_valid = 1'b0; f_pred_taken = 1'b0;
        @(negedge clk);
        ex_valid = 1'b1; ex_pc = epc; ex_opcode = op; ex_target = tgt;
        lflag = l; gflag = g; zflag = z; upd_ready = rdy;
        @(negedge clk);
        ex_valid = 1'b0; ex_opcode = 4'b0000; upd_ready = 1'b0;
    endtask

    task automatic pop_one();
        upd_ready = 1'b1;
        @(negedge clk);
        upd_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; f_valid = 1'b0; f_pc = '0; f_pred_taken = 1'b0; f_pred_tgt = '0;
        ex_valid = 1'b0; ex_pc = '0; ex_opcode = '0; ex_target = '0;
        lflag = 1'b0; gflag = 1'b0; zflag = 1'b0; upd_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({flush, redirect_vld, redirect_pc, upd_valid, upd_pc, upd_target, upd_taken} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: flush=%0b rv=%0b rpc=%h uv=%0b upc=%h ut=%h utk=%0b required all 0",
                     flush, redirect_vld, redirect_pc, upd_valid, upd_pc, upd_target, upd_taken);
        end
        checks++;
        if ({branch_cnt, mispred_cnt, drop_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_counters: %0d %0d %0d required 0 0 0", branch_cnt, mispred_cnt, drop_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_correct_jump();
        issue(16'h0010, 1'b1, 16'h0040, 16'h0010, 4'b0110, 16'h0040, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (flush !== 1'b0 || redirect_vld !== 1'b0) begin
            errors++;
            $display("FAIL correct_no_flush: flush=%0b rv=%0b required 0 0", flush, redirect_vld);
        end
        checks++;
        if (upd_valid !== 1'b1 || upd_pc !== 16'h0010 || upd_target !== 16'h0040 || upd_taken !== 1'b1) begin
            errors++;
            $display("FAIL correct_upd: v=%0b pc=%h tgt=%h tk=%0b required 1 0010 0040 1",
                     upd_valid, upd_pc, upd_target, upd_taken);
        end
        checks++;
        if (branch_cnt !== 16'd1 || mispred_cnt !== 16'd0) begin
            errors++;
            $display("FAIL correct_cnt: branch=%0d mispred=%0d required 1 0", branch_cnt, mispred_cnt);
        end
        pop_one();
        checks++;
        if (upd_valid !== 1'b0) begin
            errors++;
            $display("FAIL correct_pop: upd_valid=%0b required 0", upd_valid);
        end
    endtask

    task automatic test_mispredict_dir();
        issue(16'h0010, 1'b1, 16'h0040, 16'h0010, 4'b1001, 16'h0040, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (redirect_vld !== 1'b1 || redirect_pc !== 16'h0011 || flush !== 1'b1) begin
            errors++;
            $display("FAIL dir_redirect: rv=%0b rpc=%h flush=%0b required 1 0011 1",
                     redirect_vld, redirect_pc, flush);
        end
        checks++;
        if (mispred_cnt !== 16'd1 || branch_cnt !== 16'd2 || upd_taken !== 1'b0) begin
            errors++;
            $display("FAIL dir_cnt: mispred=%0d branch=%0d upd_taken=%0b required 1 2 0",
                     mispred_cnt, branch_cnt, upd_taken);
        end
        @(negedge clk);
        checks++;
        if (redirect_vld !== 1'b0 || flush !== 1'b1) begin
            errors++;
            $display("FAIL dir_flush2: rv=%0b flush=%0b required 0 1", redirect_vld, flush);
        end
        @(negedge clk);
        checks++;
        if (flush !== 1'b0) begin
            errors++;
            $display("FAIL dir_flush_end: flush=%0b required 0", flush);
        end
        pop_one();
    endtask

    task automatic test_mispredict_tgt();
        issue(16'h0020, 1'b1, 16'h0050, 16'h0020, 4'b0111, 16'h0060, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (redirect_vld !== 1'b1 || redirect_pc !== 16'h0060) begin
            errors++;
            $display("FAIL tgt_redirect: rv=%0b rpc=%h required 1 0060", redirect_vld, redirect_pc);
        end
        checks++;
        if (upd_taken !== 1'b1 || upd_target !== 16'h0060 || mispred_cnt !== 16'd2) begin
            errors++;
            $display("FAIL tgt_upd: tk=%0b tgt=%h mispred=%0d required 1 0060 2",
                     upd_taken, upd_target, mispred_cnt);
        end
        repeat (2) @(negedge clk);
        pop_one();
    endtask

    task automatic test_queue_full();
        for (int i = 0; i < 3; i++) begin
            issue(16'h0030 + 16'(i), 1'b1, 16'h0070 + 16'(i), 16'h0030 + 16'(i), 4'b0110,
                  16'h0070 + 16'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        checks++;
        if (drop_cnt !== 16'd1 || branch_cnt !== 16'd6) begin
            errors++;
            $display("FAIL full_drop: drop=%0d branch=%0d required 1 6", drop_cnt, branch_cnt);
        end
        checks++;
        if (upd_valid !== 1'b1 || upd_pc !== 16'h0030 || upd_target !== 16'h0070) begin
            errors++;
            $display("FAIL full_head0: v=%0b pc=%h tgt=%h required 1 0030 0070", upd_valid, upd_pc, upd_target);
        end
        upd_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (upd_valid !== 1'b1 || upd_pc !== 16'h0031 || upd_target !== 16'h0071) begin
            errors++;
            $display("FAIL full_head1: v=%0b pc=%h tgt=%h required 1 0031 0071", upd_valid, upd_pc, upd_target);
        end
        @(negedge clk);
        upd_ready = 1'b0;
        checks++;
        if (upd_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_empty: upd_valid=%0b required 0", upd_valid);
        end
    endtask

    task automatic test_full_push_pop();
        issue(16'h0040, 1'b1, 16'h0080, 16'h0040, 4'b0110, 16'h0080, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(16'h0041, 1'b1, 16'h0081, 16'h0041, 4'b0110, 16'h0081, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(16'h0042, 1'b1, 16'h0082, 16'h0042, 4'b0110, 16'h0082, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (drop_cnt !== 16'd1 || upd_pc !== 16'h0041 || upd_valid !== 1'b1) begin
            errors++;
            $display("FAIL pushpop_head: drop=%0d pc=%h v=%0b required 1 0041 1", drop_cnt, upd_pc, upd_valid);
        end
        pop_one();
        checks++;
        if (upd_valid !== 1'b1 || upd_pc !== 16'h0042) begin
            errors++;
            $display("FAIL pushpop_next: v=%0b pc=%h required 1 0042", upd_valid, upd_pc);
        end
        pop_one();
    endtask

    task automatic test_alias();
        issue(16'h0080, 1'b1, 16'h0090, 16'h0080, 4'b0001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (redirect_vld !== 1'b1 || redirect_pc !== 16'h0081 || flush !== 1'b1) begin
            errors++;
            $display("FAIL alias_redirect: rv=%0b rpc=%h flush=%0b required 1 0081 1",
                     redirect_vld, redirect_pc, flush);
        end
        checks++;
        if (upd_valid !== 1'b1 || upd_pc !== 16'h0080 || upd_taken !== 1'b0 ||
            mispred_cnt !== 16'd3 || branch_cnt !== 16'd9) begin
            errors++;
            $display("FAIL alias_upd: v=%0b pc=%h tk=%0b mispred=%0d branch=%0d required 1 0080 0 3 9",
                     upd_valid, upd_pc, upd_taken, mispred_cnt, branch_cnt);
        end
        repeat (2) @(negedge clk);
        pop_one();
        issue(16'hFFFF, 1'b1, 16'h1234, 16'hFFFF, 4'b0001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (redirect_vld !== 1'b1 || redirect_pc !== 16'h0000 || mispred_cnt !== 16'd4) begin
            errors++;
            $display("FAIL alias_wrap: rv=%0b rpc=%h mispred=%0d required 1 0000 4",
                     redirect_vld, redirect_pc, mispred_cnt);
        end
        repeat (2) @(negedge clk);
        pop_one();
        issue(16'h0090, 1'b0, 16'h0000, 16'h0090, 4'b0001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (redirect_vld !== 1'b0 || flush !== 1'b0 || upd_valid !== 1'b0 || mispred_cnt !== 16'd4) begin
            errors++;
            $display("FAIL nonjump_quiet: rv=%0b flush=%0b uv=%0b mispred=%0d required 0 0 0 4",
                     redirect_vld, flush, upd_valid, mispred_cnt);
        end
    endtask

    task automatic test_stale();
        issue(16'h0100, 1'b1, 16'h0200, 16'h0101, 4'b0110, 16'h0200, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (redirect_vld !== 1'b1 || redirect_pc !== 16'h0200 || mispred_cnt !== 16'd5 || branch_cnt !== 16'd10) begin
            errors++;
            $display("FAIL stale: rv=%0b rpc=%h mispred=%0d branch=%0d required 1 0200 5 10",
                     redirect_vld, redirect_pc, mispred_cnt, branch_cnt);
        end
        repeat (2) @(negedge clk);
        pop_one();
    endtask

    task automatic test_reset_mid_flush();
        issue(16'h0010, 1'b0, 16'h0000, 16'h0010, 4'b0110, 16'h0040, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (flush !== 1'b1 || upd_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstflush_pre: flush=%0b uv=%0b required 1 1", flush, upd_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (flush !== 1'b0 || redirect_vld !== 1'b0 || upd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstflush_state: flush=%0b rv=%0b uv=%0b required 0 0 0", flush, redirect_vld, upd_valid);
        end
        checks++;
        if ({branch_cnt, mispred_cnt, drop_cnt} !== '0) begin
            errors++;
            $display("FAIL rstflush_cnt: %0d %0d %0d required 0 0 0", branch_cnt, mispred_cnt, drop_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_correct_jump();
        test_mispredict_dir();
        test_mispredict_tgt();
        test_queue_full();
        test_full_push_pop();
        test_alias();
        test_stale();
        test_reset_mid_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
